// File: rtl/vga_timing_driver_if.sv
// vga_timing_driver_if: coordinate/pixel bus between the VGA timing driver (master) and the display stage (slave)
// Signals: pixel_hpos/pixel_vpos/pixel_req/frame_start flow to the display stage; pixel_data returns from it.
interface vga_timing_driver_if;
  logic [9:0]  pixel_hpos;
  logic [9:0]  pixel_vpos;
  logic        pixel_req;
  logic        frame_start;
  logic [15:0] pixel_data;
  modport master (
    output pixel_hpos, pixel_vpos, pixel_req, frame_start,
    input  pixel_data
  );
  modport slave (
    input  pixel_hpos, pixel_vpos, pixel_req, frame_start,
    output pixel_data
  );
endinterface

// File: rtl/vga_timing_driver.sv
// vga_timing_driver: 640x480@60 raster timing generator with delay-matched sync/DE/RGB565 output stage
// Ports: clk_25MHz pixel clock; rst synchronous active-high reset; pix (master) coordinates out, pixel_data in;
//        vga_hs/vga_vs/vga_de/vga_rgb drive the pins. Define VGA_BORDER_EN to paint a white active-area border.
module vga_timing_driver #(
  parameter int H_DISP     = 640,
  parameter int H_FRONT    = 16,
  parameter int H_SYNC     = 96,
  parameter int H_BACK     = 48,
  parameter int V_DISP     = 480,
  parameter int V_FRONT    = 10,
  parameter int V_SYNC     = 2,
  parameter int V_BACK     = 33,
  parameter int PIPE_DELAY = 3,
  parameter bit SYNC_POL   = 1'b0
) (
  input  logic                clk_25MHz,
  input  logic                rst,
  vga_timing_driver_if.master pix,
  output logic                vga_hs,
  output logic                vga_vs,
  output logic                vga_de,
  output logic [15:0]         vga_rgb
);
  localparam int H_TOT = H_DISP + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOT = V_DISP + V_FRONT + V_SYNC + V_BACK;
`ifdef VGA_BORDER_EN
  localparam int W = 4;
`else
  localparam int W = 3;
`endif
  localparam logic [9:0] H_ACT  = 10'(H_DISP);
  localparam logic [9:0] V_ACT  = 10'(V_DISP);
  localparam logic [9:0] H_LAST = 10'(H_TOT - 1);
  localparam logic [9:0] V_LAST = 10'(V_TOT - 1);
  localparam logic [9:0] HS_BEG = 10'(H_DISP + H_FRONT);
  localparam logic [9:0] HS_END = 10'(H_DISP + H_FRONT + H_SYNC);
  localparam logic [9:0] VS_BEG = 10'(V_DISP + V_FRONT);
  localparam logic [9:0] VS_END = 10'(V_DISP + V_FRONT + V_SYNC);
  logic [9:0]   h_cnt, v_cnt;
  logic         act, hs_on, vs_on;
  // timing bits, internally active-high: [0] hs, [1] vs, [2] de, [3] border
  logic [W-1:0] dec, cur, last;
  logic [W-1:0] chain [PIPE_DELAY];
  logic [15:0]  rgb_next;
  assign act   = h_cnt < H_ACT && v_cnt < V_ACT;
  assign hs_on = h_cnt >= HS_BEG && h_cnt < HS_END;
  assign vs_on = v_cnt >= VS_BEG && v_cnt < VS_END;
  assign last  = chain[PIPE_DELAY-1];
`ifdef VGA_BORDER_EN
  assign dec = {act && (h_cnt == 10'd0 || h_cnt == H_ACT - 10'd1 || v_cnt == 10'd0 || v_cnt == V_ACT - 10'd1),
                act, vs_on, hs_on};
  assign rgb_next = !last[2] ? 16'h0000 : last[3] ? 16'hFFFF : pix.pixel_data;
`else
  assign dec = {act, vs_on, hs_on};
  assign rgb_next = last[2] ? pix.pixel_data : 16'h0000;
`endif
  always_ff @(posedge clk_25MHz) begin
    if (rst) begin
      h_cnt           <= '0;
      v_cnt           <= '0;
      pix.pixel_hpos  <= '0;
      pix.pixel_vpos  <= '0;
      pix.pixel_req   <= 1'b0;
      pix.frame_start <= 1'b0;
      cur             <= '0;
      for (int i = 0; i < PIPE_DELAY; i++) chain[i] <= '0;
      vga_hs          <= ~SYNC_POL;
      vga_vs          <= ~SYNC_POL;
      vga_de          <= 1'b0;
      vga_rgb         <= '0;
    end else begin
      h_cnt <= h_cnt == H_LAST ? '0 : h_cnt + 10'd1;
      if (h_cnt == H_LAST) v_cnt <= v_cnt == V_LAST ? '0 : v_cnt + 10'd1;
      pix.pixel_hpos  <= act ? h_cnt : '0;
      pix.pixel_vpos  <= act ? v_cnt : '0;
      pix.pixel_req   <= act;
      pix.frame_start <= h_cnt == 10'd0 && v_cnt == 10'd0;
      cur             <= dec;
      // PIPE_DELAY stages line the timing bits up with the display stage's pixel_data
      chain[0]        <= cur;
      for (int i = 1; i < PIPE_DELAY; i++) chain[i] <= chain[i-1];
      vga_hs          <= last[0] ? SYNC_POL : ~SYNC_POL;
      vga_vs          <= last[1] ? SYNC_POL : ~SYNC_POL;
      vga_de          <= last[2];
      vga_rgb         <= rgb_next;
    end
  end
endmodule

// File: tb/tb_vga_timing_driver.sv
// tb_vga_timing_driver: directed checks of raster timing, latency alignment and reset on a reduced-size raster
module tb_vga_timing_driver;
  // reduced raster: H 8+2+3+2 = 15 clocks/line, V 4+1+2+1 = 8 lines/frame, 120 clocks/frame
  localparam int P = 3;
  logic clk_25MHz = 1'b0;
  logic rst = 1'b1;
  logic vga_hs, vga_vs, vga_de;
  logic [15:0] vga_rgb;
  logic [15:0] hist [8];
  int n_cmp = 0, n_bad = 0;
  int req_cnt, fs_cnt, fs_gap, last_fs, max_v, de_cnt, hs_cnt, vs_cnt, first_hs;
  vga_timing_driver_if pix();
  vga_timing_driver #(
    .H_DISP(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(2),
    .V_DISP(4), .V_FRONT(1), .V_SYNC(2), .V_BACK(1),
    .PIPE_DELAY(P), .SYNC_POL(1'b0)
  ) dut (
    .clk_25MHz(clk_25MHz),
    .rst(rst),
    .pix(pix),
    .vga_hs(vga_hs),
    .vga_vs(vga_vs),
    .vga_de(vga_de),
    .vga_rgb(vga_rgb)
  );
  always #20 clk_25MHz = ~clk_25MHz;
  function automatic logic [15:0] f(input logic [9:0] h, input logic [9:0] v);
    return {h[5:0], v} ^ 16'hA5A5;
  endfunction
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  // display stage model: fixed latency of P clocks from coordinate to pixel_data
  task automatic drive();
    for (int i = 7; i > 0; i--) hist[i] = hist[i-1];
    hist[0] = f(pix.pixel_hpos, pix.pixel_vpos);
    pix.pixel_data = hist[P];
  endtask
  task automatic check_reset(input string tag);
    chk({tag, "_hpos"}, 32'(pix.pixel_hpos), 0);
    chk({tag, "_vpos"}, 32'(pix.pixel_vpos), 0);
    chk({tag, "_req"}, 32'(pix.pixel_req), 0);
    chk({tag, "_fs"}, 32'(pix.frame_start), 0);
    chk({tag, "_hs"}, 32'(vga_hs), 1);
    chk({tag, "_vs"}, 32'(vga_vs), 1);
    chk({tag, "_de"}, 32'(vga_de), 0);
    chk({tag, "_rgb"}, 32'(vga_rgb), 0);
  endtask
  task automatic run(input int n);
    int h, v, c, hc, vc;
    logic a, ok, ea;
    logic [15:0] erg;
    req_cnt = 0; fs_cnt = 0; fs_gap = 0; last_fs = 0; max_v = 0;
    de_cnt = 0; hs_cnt = 0; vs_cnt = 0; first_hs = -1;
    for (int t = 0; t < n; t++) begin
      @(negedge clk_25MHz);
      h = t % 15;
      v = (t / 15) % 8;
      a = h < 8 && v < 4;
      chk("hpos", 32'(pix.pixel_hpos), a ? h : 0);
      chk("vpos", 32'(pix.pixel_vpos), a ? v : 0);
      chk("req", 32'(pix.pixel_req), 32'(a));
      chk("frame_start", 32'(pix.frame_start), 32'(h == 0 && v == 0));
      ok = t >= P + 1;
      c  = ok ? t - P - 1 : 0;
      hc = c % 15;
      vc = (c / 15) % 8;
      ea = ok && hc < 8 && vc < 4;
      erg = ea ? f(10'(hc), 10'(vc)) : 16'h0000;
`ifdef VGA_BORDER_EN
      if (ea && (hc == 0 || hc == 7 || vc == 0 || vc == 3)) erg = 16'hFFFF;
`endif
      chk("vga_de", 32'(vga_de), 32'(ea));
      chk("vga_hs", 32'(vga_hs), 32'(!(ok && hc >= 10 && hc <= 12)));
      chk("vga_vs", 32'(vga_vs), 32'(!(ok && vc >= 5 && vc <= 6)));
      chk("vga_rgb", 32'(vga_rgb), 32'(erg));
      if (t < 240) begin
        if (pix.pixel_req) req_cnt++;
        if (pix.frame_start) begin
          if (fs_cnt > 0) fs_gap = t - last_fs;
          last_fs = t;
          fs_cnt++;
        end
        if (int'(pix.pixel_vpos) > max_v) max_v = int'(pix.pixel_vpos);
      end
      if (ok && t < 240 + P + 1) begin
        if (vga_de) de_cnt++;
        if (!vga_hs) hs_cnt++;
        if (!vga_vs) vs_cnt++;
        if (!vga_hs && first_hs < 0) first_hs = t;
      end
      drive();
    end
  endtask
  initial begin
    pix.pixel_data = '0;
    for (int i = 0; i < 8; i++) hist[i] = '0;
    rst = 1'b1;
    repeat (3) @(negedge clk_25MHz);
    check_reset("init");
    rst = 1'b0;
    run(300);
    chk("req_per_2frames", req_cnt, 64);
    chk("frame_start_count", fs_cnt, 2);
    chk("frame_start_gap", fs_gap, 120);
    chk("max_vpos", max_v, 3);
    chk("de_per_2frames", de_cnt, 64);
    chk("hs_low_per_2frames", hs_cnt, 48);
    chk("vs_low_per_2frames", vs_cnt, 60);
    chk("first_hs_low", first_hs, 14);
    rst = 1'b1;
    repeat (5) begin
      @(negedge clk_25MHz);
      drive();
    end
    check_reset("mid");
    rst = 1'b0;
    run(60);
    chk("restart_frame_start_count", fs_cnt, 1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/vga_timing_driver.md
# vga_timing_driver

Raster timing generator and output stage for the 640x480@60 Hz VGA path. It generates the horizontal and vertical counters and presents the pixel coordinates to the display/framebuffer stage (`vga_display`). It accepts that stage's `pixel_data` a fixed number of cycles later and drives the pins (sync, data-enable and RGB565) with sync and blanking delay-matched to the data.

## Interface
Parameters:
- `H_DISP`, 640, active pixels per line
- `H_FRONT`, 16, horizontal front porch (clocks)
- `H_SYNC`, 96, hsync width (clocks)
- `H_BACK`, 48, horizontal back porch (clocks)
- `V_DISP`, 480, active lines per frame
- `V_FRONT`, 10, vertical front porch (lines)
- `V_SYNC`, 2, vsync width (lines)
- `V_BACK`, 33, vertical back porch (lines)
- `PIPE_DELAY`, 3, clocks from coordinate presentation to the sampling of `pixel_data`; legal range 1..7
- `SYNC_POL`, 0, sync polarity during the sync interval (0 = active-low)

Ports:
- `clk_25MHz`  in  1  pixel clock; single clock domain
- `rst`  in  1  synchronous, active-high reset
- `pixel_data`  in  16  RGB565 from the display stage
- `pixel_hpos`  out  10  active-area column 0..H_DISP-1; 0 outside active area
- `pixel_vpos`  out  10  active-area row 0..V_DISP-1; 0 outside active area
- `pixel_req`  out  1  high when (`pixel_hpos`, `pixel_vpos`) is an active pixel
- `frame_start`  out  1  one-cycle pulse coincident with coordinate (0,0)
- `vga_hs`  out  1  horizontal sync
- `vga_vs`  out  1  vertical sync
- `vga_de`  out  1  data enable (active video)
- `vga_rgb`  out  16  RGB565 pin data; 0 when `vga_de` is low

## Operation
- Line total is `H_TOT` = H_DISP+H_FRONT+H_SYNC+H_BACK (800). Frame total is `V_TOT` = V_DISP+V_FRONT+V_SYNC+V_BACK (525).
- `h_cnt` counts 0..H_TOT-1 and wraps to 0. When `h_cnt` wraps, `v_cnt` increments; `v_cnt` wraps from V_TOT-1 to 0 on the same edge.
- Counter regions:
  - Active when `h_cnt` < H_DISP and `v_cnt` < V_DISP.
  - hsync asserted for H_DISP+H_FRONT <= `h_cnt` < H_DISP+H_FRONT+H_SYNC (656..751).
  - vsync asserted for V_DISP+V_FRONT <= `v_cnt` < V_DISP+V_FRONT+V_SYNC (490..491), for whole lines.
- Coordinate stage (one register): each edge captures the decode of the current counters into `pixel_hpos`/`pixel_vpos`/`pixel_req`/`frame_start` and the internal hs/vs/de bits.
- Delay chain: the hs/vs/de bits (plus border flag, if configured) pass through PIPE_DELAY shift stages.
- Output register: each edge loads `vga_hs`/`vga_vs`/`vga_de` from the last chain stage. On the same edge, `vga_rgb` <= last-stage de ? `pixel_data` : 0.
- Width rules:
  - Counters are 10 bits; H_TOT and V_TOT must be <= 1024.
  - The sync level is SYNC_POL when asserted and ~SYNC_POL otherwise.

## Timing
- Reset behaviour:
  - While `rst` is high at an edge: counters go to 0, all chain stages clear, `pixel_hpos`=0, `pixel_vpos`=0, `pixel_req`=0, `frame_start`=0, `vga_de`=0, `vga_rgb`=0, `vga_hs`=`vga_vs`=~SYNC_POL.
  - Reset mid-frame has the same effect; no partial line is emitted afterwards.
- First edge with `rst` low: presents coordinate (0,0) with `pixel_req`=1 and `frame_start`=1, and advances `h_cnt` to 1.
- Latency:
  - Coordinates presented in cycle n: `pixel_data` is sampled at the edge ending cycle n+PIPE_DELAY.
  - The corresponding `vga_rgb`/`vga_de`/`vga_hs`/`vga_vs` are visible in cycle n+PIPE_DELAY+1.
  - The display stage must hold a fixed latency equal to PIPE_DELAY.
- Steady state:
  - `pixel_req` is high H_DISP consecutive cycles per active line.
  - `frame_start` occurs every H_TOT*V_TOT = 420000 cycles.
  - No handshake back-pressure; `pixel_data` is ignored when the delayed de is 0.
- Simultaneous events: the h wrap and the v wrap at (H_TOT-1, V_TOT-1) occur on one edge. The next presented coordinate is (0,0) with `frame_start`.

## Configuration
- `VGA_BORDER_EN` defined:
  - A border flag is decoded at the coordinate stage (active and (hpos==0 or hpos==H_DISP-1 or vpos==0 or vpos==V_DISP-1)) and delayed with de.
  - When the delayed flag is set, `vga_rgb` = 16'hFFFF instead of `pixel_data`.
- `VGA_BORDER_EN` undefined: no border logic; `vga_rgb` passes `pixel_data` on every active pixel.

## Test plan
- Reset: hold `rst` 5 cycles mid-frame -> all outputs at reset values. First edge after release gives `pixel_hpos`=0, `pixel_vpos`=0, `pixel_req`=1, `frame_start`=1.
- Line timing: count from `frame_start` -> `pixel_req` high 640 cycles, low 160. `vga_hs` low for exactly 96 cycles, starting 656+PIPE_DELAY+1 cycles after a line's first coordinate.
- Frame timing: `frame_start` spacing = 420000 cycles. `vga_vs` low for 1600 cycles. `pixel_vpos` reaches 479 and never 480.
- Alignment: model the display stage with `pixel_data`={hpos[5:0],vpos[9:0]} delayed PIPE_DELAY=3 -> every `vga_de`=1 cycle shows the value for the correct coordinate. `vga_rgb`=0 whenever `vga_de`=0.
- PIPE_DELAY=1 and 7 variants -> same alignment check passes. Sync-to-de relationship is unchanged.
- With `VGA_BORDER_EN` and `pixel_data`=16'h0000 -> `vga_rgb`=16'hFFFF on columns 0/639 and rows 0/479 only. Without the macro -> always 16'h0000.
